// File: rtl/multicycle_ctrl_pkg.sv
// Shared definitions for the multicycle RISC-V controller and its datapath ALU:
// ALU operation codes, opcodes, FSM state encoding and mux select codes.
package multicycle_ctrl_pkg;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'h0,
        ALU_SUB  = 4'h1,
        ALU_OR   = 4'h2,
        ALU_AND  = 4'h3,
        ALU_XOR  = 4'h4,
        ALU_SLL  = 4'h5,
        ALU_SRL  = 4'h6,
        ALU_SRA  = 4'h7,
        ALU_SLT  = 4'h8,
        ALU_SLTU = 4'h9,
        ALU_GEQ  = 4'hA,
        ALU_GEQU = 4'hB
    } alu_op_e;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
        S_EXECR, S_EXECI, S_ALUWB, S_BRANCH, S_JAL, S_JALR, S_LUI
    } state_e;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;
    localparam logic [1:0] SRCA_ZERO  = 2'b11;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_RDATA  = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

    // Immediate format depends only on the opcode, so it is valid in every state.
    function automatic logic [2:0] imm_src_of(input logic [6:0] opcode);
        case (opcode)
            OP_STORE:  return IMM_S;
            OP_BRANCH: return IMM_B;
            OP_JAL:    return IMM_J;
            OP_LUI:    return IMM_U;
            default:   return IMM_I;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_ctrl_alu_dec.sv
// Combinational funct3/funct7 decode to an ALU operation for R- and I-type
// arithmetic instructions.
module alu_dec
    import multicycle_ctrl_pkg::*;
(
    input  logic [2:0] funct3,
    input  logic       funct7_b5,
    input  logic       is_rtype,
    output alu_op_e    alu_op
);

    always_comb begin
        alu_op = ALU_ADD;
        case (funct3)
            3'b000: alu_op = (is_rtype && funct7_b5) ? ALU_SUB : ALU_ADD;
            3'b001: alu_op = ALU_SLL;
            3'b010: alu_op = ALU_SLT;
            3'b011: alu_op = ALU_SLTU;
            3'b100: alu_op = ALU_XOR;
            // funct7[5] selects arithmetic shift for both srai and sra
            3'b101: alu_op = funct7_b5 ? ALU_SRA : ALU_SRL;
            3'b110: alu_op = ALU_OR;
            3'b111: alu_op = ALU_AND;
            default: alu_op = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Main FSM of a multicycle RV32I processor: sequences fetch, decode, execute,
// memory and writeback steps and drives datapath selects and write strobes.
module multicycle_ctrl
    import multicycle_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instr,
    input  logic        mem_ready,
    input  logic        alu_z,
    input  logic        alu_iqf,
    output logic [3:0]  alu_control,
    output logic [1:0]  alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [1:0]  result_src,
    output logic [2:0]  imm_src,
    output logic        adr_src,
    output logic        pc_write,
    output logic        ir_write,
    output logic        reg_write,
    output logic        mem_write,
    output logic        illegal
);

    state_e     state_q, state_d;
    logic       run_q;
    alu_op_e    arith_op;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       unused_instr_bits;

    assign opcode            = instr[6:0];
    assign funct3            = instr[14:12];
    assign unused_instr_bits = ^{instr[31], instr[29:15], instr[11:7]};

    alu_dec u_alu_dec (
        .funct3    (funct3),
        .funct7_b5 (instr[30]),
        .is_rtype  (state_q == S_EXECR),
        .alu_op    (arith_op)
    );

    // run_q keeps every strobe quiet until the first rising edge after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
            run_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            run_q   <= 1'b1;
        end
    end

    always_comb begin
        state_d     = state_q;
        alu_control = ALU_ADD;
        alu_src_a   = SRCA_PC;
        alu_src_b   = SRCB_RS2;
        result_src  = RES_ALUOUT;
        imm_src     = imm_src_of(opcode);
        adr_src     = 1'b0;
        pc_write    = 1'b0;
        ir_write    = 1'b0;
        reg_write   = 1'b0;
        mem_write   = 1'b0;
        illegal     = 1'b0;

        case (state_q)
            S_FETCH: begin
                alu_src_b  = SRCB_FOUR;
                result_src = RES_ALU;
                ir_write   = mem_ready;
                pc_write   = mem_ready;
                if (mem_ready) state_d = S_DECODE;
            end
            S_DECODE: begin
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_IMM;
                case (opcode)
                    OP_LOAD, OP_STORE: state_d = S_MEMADR;
                    OP_RTYPE:          state_d = S_EXECR;
                    OP_ITYPE:          state_d = S_EXECI;
                    OP_BRANCH:         state_d = S_BRANCH;
                    OP_JAL:            state_d = S_JAL;
                    OP_JALR:           state_d = S_JALR;
                    OP_LUI:            state_d = S_LUI;
                    default: begin
                        illegal = 1'b1;
                        state_d = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_IMM;
                state_d   = (opcode == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                adr_src = 1'b1;
                if (mem_ready) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                result_src = RES_RDATA;
                reg_write  = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEMWRITE: begin
                adr_src   = 1'b1;
                mem_write = 1'b1;
                if (mem_ready) state_d = S_FETCH;
            end
            S_EXECR, S_EXECI: begin
                alu_src_a   = SRCA_RS1;
                alu_src_b   = (state_q == S_EXECR) ? SRCB_RS2 : SRCB_IMM;
                alu_control = arith_op;
                state_d     = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write = 1'b1;
                state_d   = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a = SRCA_RS1;
                // signed/unsigned compares report their outcome on alu_iqf
                case (funct3)
                    3'b000: begin alu_control = ALU_SUB;  pc_write = alu_z;   end
                    3'b001: begin alu_control = ALU_SUB;  pc_write = !alu_z;  end
                    3'b100: begin alu_control = ALU_SLT;  pc_write = alu_iqf; end
                    3'b101: begin alu_control = ALU_GEQ;  pc_write = alu_iqf; end
                    3'b110: begin alu_control = ALU_SLTU; pc_write = alu_iqf; end
                    3'b111: begin alu_control = ALU_GEQU; pc_write = alu_iqf; end
                    default: illegal = 1'b1;
                endcase
                state_d = S_FETCH;
            end
            S_JAL: begin
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_FOUR;
                pc_write  = 1'b1;
                state_d   = S_ALUWB;
            end
            S_JALR: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_IMM;
                state_d   = S_JAL;
            end
            S_LUI: begin
                alu_src_a = SRCA_ZERO;
                alu_src_b = SRCB_IMM;
                state_d   = S_ALUWB;
            end
            default: state_d = S_FETCH;
        endcase

        if (!run_q) begin
            pc_write  = 1'b0;
            ir_write  = 1'b0;
            reg_write = 1'b0;
            mem_write = 1'b0;
            illegal   = 1'b0;
            state_d   = S_FETCH;
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed table-driven check of the multicycle controller, plus hand-written
// reset-timing sequences.
module tb_multicycle_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] instr;
    logic        mem_ready, alu_z, alu_iqf;
    logic [3:0]  alu_control;
    logic [1:0]  alu_src_a, alu_src_b, result_src;
    logic [2:0]  imm_src;
    logic        adr_src, pc_write, ir_write, reg_write, mem_write, illegal;

    always #5 clk = ~clk;

    multicycle_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .instr       (instr),
        .mem_ready   (mem_ready),
        .alu_z       (alu_z),
        .alu_iqf     (alu_iqf),
        .alu_control (alu_control),
        .alu_src_a   (alu_src_a),
        .alu_src_b   (alu_src_b),
        .result_src  (result_src),
        .imm_src     (imm_src),
        .adr_src     (adr_src),
        .pc_write    (pc_write),
        .ir_write    (ir_write),
        .reg_write   (reg_write),
        .mem_write   (mem_write),
        .illegal     (illegal)
    );

    typedef struct {
        logic [31:0] instr;
        logic        mr;
        logic        z;
        logic        iqf;
        logic [18:0] exp;
    } vec_t;

    vec_t vecs[96];
    int   nvec   = 0;
    int   errors = 0;
    int   checks = 0;

    wire [18:0] act = {alu_control, alu_src_a, alu_src_b, result_src, imm_src,
                       adr_src, pc_write, ir_write, reg_write, mem_write, illegal};

    // Expected-output word: {alu_control, A, B, result, imm, adr, pc, ir, reg, mem, illegal}
    function automatic logic [18:0] ex(input logic [3:0] ac, input logic [1:0] a,
                                       input logic [1:0] b, input logic [1:0] r,
                                       input logic [2:0] imm, input logic adr,
                                       input logic pc, input logic ir, input logic rw,
                                       input logic mw, input logic il);
        return {ac, a, b, r, imm, adr, pc, ir, rw, mw, il};
    endfunction

    function automatic logic [18:0] f_exp(input logic [2:0] imm);
        return ex(4'h0, 2'd0, 2'd2, 2'd2, imm, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    endfunction

    function automatic logic [18:0] d_exp(input logic [2:0] imm);
        return ex(4'h0, 2'd1, 2'd1, 2'd0, imm, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endfunction

    function automatic logic [18:0] wb_exp(input logic [2:0] imm);
        return ex(4'h0, 2'd0, 2'd0, 2'd0, imm, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    endfunction

    task automatic add(input logic [31:0] i, input logic mr, input logic z,
                       input logic iqf, input logic [18:0] e);
        vecs[nvec] = '{instr: i, mr: mr, z: z, iqf: iqf, exp: e};
        nvec++;
    endtask

    task automatic check(input string tag, input logic [18:0] e);
        checks++;
        if (act !== e) begin
            errors++;
            $display("FAIL %s: got %05h expected %05h", tag, act, e);
        end
    endtask

    task automatic drive(input logic [31:0] i, input logic mr, input logic z, input logic iqf);
        instr     = i;
        mem_ready = mr;
        alu_z     = z;
        alu_iqf   = iqf;
    endtask

    // Normal fetch/decode pair for instruction i with immediate format imm
    task automatic add_fd(input logic [31:0] i, input logic [2:0] imm);
        add(i, 1'b1, 1'b0, 1'b0, f_exp(imm));
        add(i, 1'b1, 1'b0, 1'b0, d_exp(imm));
    endtask

    initial begin
        logic [18:0] quiet_fetch;
        quiet_fetch = ex(4'h0, 2'd0, 2'd2, 2'd2, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // add / sub
        add_fd(32'h002081B3, 3'd0);
        add(32'h002081B3, 1, 0, 0, ex(4'h0, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        add(32'h002081B3, 1, 0, 0, wb_exp(3'd0));
        add_fd(32'h402081B3, 3'd0);
        add(32'h402081B3, 1, 0, 0, ex(4'h1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        add(32'h402081B3, 1, 0, 0, wb_exp(3'd0));
        // fetch stall, then beq taken / not taken
        add(32'h00208463, 0, 0, 0, ex(4'h0, 0, 2, 2, 2, 0, 0, 0, 0, 0, 0));
        add(32'h00208463, 0, 0, 0, ex(4'h0, 0, 2, 2, 2, 0, 0, 0, 0, 0, 0));
        add_fd(32'h00208463, 3'd2);
        add(32'h00208463, 1, 1, 0, ex(4'h1, 2, 0, 0, 2, 0, 1, 0, 0, 0, 0));
        add_fd(32'h00208463, 3'd2);
        add(32'h00208463, 1, 0, 1, ex(4'h1, 2, 0, 0, 2, 0, 0, 0, 0, 0, 0));
        // blt follows alu_iqf, ignores alu_z
        add_fd(32'h0020C463, 3'd2);
        add(32'h0020C463, 1, 0, 1, ex(4'h8, 2, 0, 0, 2, 0, 1, 0, 0, 0, 0));
        add_fd(32'h0020C463, 3'd2);
        add(32'h0020C463, 1, 1, 0, ex(4'h8, 2, 0, 0, 2, 0, 0, 0, 0, 0, 0));
        // branch funct3 010 is illegal
        add_fd(32'h0020A463, 3'd2);
        add(32'h0020A463, 1, 1, 1, ex(4'h0, 2, 0, 0, 2, 0, 0, 0, 0, 0, 1));
        // lw with three wait cycles in MEMREAD
        add_fd(32'h0000A183, 3'd0);
        add(32'h0000A183, 1, 0, 0, ex(4'h0, 2, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        for (int k = 0; k < 4; k++)
            add(32'h0000A183, (k == 3), 0, 0, ex(4'h0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
        add(32'h0000A183, 1, 0, 0, ex(4'h0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0));
        // sw with one wait cycle
        add_fd(32'h0020A023, 3'd1);
        add(32'h0020A023, 1, 0, 0, ex(4'h0, 2, 1, 0, 1, 0, 0, 0, 0, 0, 0));
        add(32'h0020A023, 0, 0, 0, ex(4'h0, 0, 0, 0, 1, 1, 0, 0, 0, 1, 0));
        add(32'h0020A023, 1, 0, 0, ex(4'h0, 0, 0, 0, 1, 1, 0, 0, 0, 1, 0));
        // unsupported opcode
        add(32'h00000000, 1, 0, 0, f_exp(3'd0));
        add(32'h00000000, 1, 0, 0, ex(4'h0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1));
        // srai, then addi with bit 30 set stays ADD
        add_fd(32'h40515093, 3'd0);
        add(32'h40515093, 1, 0, 0, ex(4'h7, 2, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        add(32'h40515093, 1, 0, 0, wb_exp(3'd0));
        add_fd(32'h40008093, 3'd0);
        add(32'h40008093, 1, 0, 0, ex(4'h0, 2, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        add(32'h40008093, 1, 0, 0, wb_exp(3'd0));
        // jal, jalr, lui
        add_fd(32'h0000006F, 3'd3);
        add(32'h0000006F, 1, 0, 0, ex(4'h0, 1, 2, 0, 3, 0, 1, 0, 0, 0, 0));
        add(32'h0000006F, 1, 0, 0, wb_exp(3'd3));
        add_fd(32'h00008067, 3'd0);
        add(32'h00008067, 1, 0, 0, ex(4'h0, 2, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        add(32'h00008067, 1, 0, 0, ex(4'h0, 1, 2, 0, 0, 0, 1, 0, 0, 0, 0));
        add(32'h00008067, 1, 0, 0, wb_exp(3'd0));
        add_fd(32'h000000B7, 3'd4);
        add(32'h000000B7, 1, 0, 0, ex(4'h0, 3, 1, 0, 4, 0, 0, 0, 0, 0, 0));
        add(32'h000000B7, 1, 0, 0, wb_exp(3'd4));

        // Reset: strobes stay low even with mem_ready high, until the first edge after release
        rst_n = 1'b0;
        drive(32'h002081B3, 1'b1, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        #1 check("reset_hold", quiet_fetch);
        @(negedge clk);
        rst_n = 1'b1;
        #1 check("reset_release_no_edge", quiet_fetch);
        $display("reset sequence done");

        for (int v = 0; v < nvec; v++) begin
            @(negedge clk);
            drive(vecs[v].instr, vecs[v].mr, vecs[v].z, vecs[v].iqf);
            #1;
            check($sformatf("vec%0d_instr%08h", v, vecs[v].instr), vecs[v].exp);
            $display("vec %0d instr=%08h mr=%0b z=%0b iqf=%0b outputs=%05h",
                     v, vecs[v].instr, vecs[v].mr, vecs[v].z, vecs[v].iqf, act);
        end

        // Reset asserted mid-cycle while in EXECR
        @(negedge clk);
        drive(32'h402081B3, 1'b1, 1'b0, 1'b0);
        #1 check("mid_fetch", f_exp(3'd0));
        @(negedge clk);
        #1 check("mid_decode", d_exp(3'd0));
        @(negedge clk);
        #1 check("mid_execr", ex(4'h1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        #1 rst_n = 1'b0;
        #1 check("mid_reset_async", quiet_fetch);
        @(negedge clk);
        #1 check("mid_reset_held", quiet_fetch);
        rst_n = 1'b1;
        #1 check("mid_release_no_edge", quiet_fetch);
        @(negedge clk);
        #1 check("mid_first_fetch", f_exp(3'd0));
        @(negedge clk);
        #1 check("mid_resume_decode", d_exp(3'd0));
        @(negedge clk);
        #1 check("mid_resume_execr", ex(4'h1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        $display("mid-instruction reset sequence done");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
